rf_port_arbiter: RTL and testbench
==================================

// Module: rf_port_arbiter
// PURPOSE
//  Shares the 8x32 register file's single write port and single read port between two clients
//  (client 0: matrix load engine; client 1: compute engine).
//  Round-robin arbitration runs on each port independently, with a req/gnt handshake.
//  Read data comes back registered, one cycle after the grant. A flush sequencer clears all
//  registers on request. The block sits between the clients and the register file's
//  we/wAddr/wData/rAddr/rData/clear pins.
// PARAMETERS
//  DATA_W  32  register width
//  ADDR_W  3   register address width (8 entries)
// PORTS
//  clk         in   1          clock; all state updates on posedge
//  clear       in   1          synchronous, active-high reset
//  wr_req      in   2          write request per client; bit i = client i
//  wr_addr     in   2*ADDR_W   client i address at [i*ADDR_W +: ADDR_W]
//  wr_data     in   2*DATA_W   client i data at [i*DATA_W +: DATA_W]
//  wr_gnt      out  2          write grant, combinational, one-hot or zero
//  rd_req      in   2          read request per client
//  rd_addr     in   2*ADDR_W   client i read address
//  rd_gnt      out  2          read grant, combinational, one-hot or zero
//  rd_valid    out  2          registered; bit i high 1 cycle after rd_gnt[i]
//  rd_data     out  DATA_W     registered read data, qualified by rd_valid
//  flush_req   in   1          request to clear the whole register file
//  flush_done  out  1          1-cycle pulse when the flush completes
//  busy        out  1          high while the flush FSM is not in IDLE
//  rf_clear    out  1          to register file clear = clear | (state==CLEAR)
//  rf_we       out  1          to register file we = |wr_gnt
//  rf_wAddr    out  ADDR_W     address of the granted writer (0 if none)
//  rf_wData    out  DATA_W     data of the granted writer (0 if none)
//  rf_rAddr    out  ADDR_W     address of the granted reader (0 if none)
//  rf_rData    in   DATA_W     combinational read data from the register file
// BEHAVIOUR
//  Reset (clear=1):
//   - state=IDLE; wr_last=rd_last=1, so client 0 wins the first contention.
//   - rd_valid=0, rd_data=0, flush_done=0, busy=0. Grants are forced to 0.
//   - A read in flight is dropped.
//  Handshake:
//   - A transfer occurs in a cycle where req[i]&gnt[i].
//   - The client holds req, addr and data stable until granted.
//   - Responses have no backpressure.
//  Arbitration (each port separately):
//   - Exactly one requester: it is granted.
//   - Both requesting: grant the client != last.
//   - last <= the granted index on every grant.
//  Grant gating:
//   - Grants are issued only when state==IDLE and flush_req==0.
//   - If flush_req and a client req arrive in the same cycle, the flush wins.
//  Read latency:
//   - Grant in cycle T gives rd_valid[i]=1 and rd_data=rf_rData at T+1.
//   - Back-to-back reads give one response per cycle.
//  Write-read forwarding:
//   - Applies when a write and a read are granted in the same cycle with rf_wAddr==rf_rAddr.
//   - rd_data at T+1 = rf_wData, i.e. write-first semantics.
//  Flush FSM: IDLE -> DRAIN -> CLEAR -> DONE -> IDLE.
//   - IDLE  -> DRAIN when flush_req=1.
//   - DRAIN: 1 cycle; no grants; the read granted in the prior cycle still returns.
//   - CLEAR: 1 cycle; rf_clear=1; all registers read 0 afterwards.
//   - DONE:  1 cycle; flush_done=1.
//   - flush_req during DRAIN/CLEAR/DONE is ignored; re-sampled only in IDLE.
//  Mid-flush reset: clear returns to IDLE immediately; rf_clear is high during clear anyway.
//  Address/data widths pass through unchanged; no arithmetic in the datapath.
// STRUCTURE
//  Shared include rf_defs.vh:
//   - DATA_W/ADDR_W defaults.
//   - FSM state encodings: IDLE=2'd0, DRAIN=2'd1, CLEAR=2'd2, DONE=2'd3.
//  Sub-module rr_arb2(clk, clear, en, req[1:0], gnt[1:0]):
//   - 2-way round-robin with its own last pointer.
//   - Instantiated twice, for the write port and the read port.
//  Top level keeps: address/data muxes, read-response register, forwarding compare, flush FSM.
// TESTING
//  1 Reset, then wr_req=2'b01, addr 3, data 32'hDEAD_BEEF
//    -> wr_gnt=01, rf_we=1, rf_wAddr=3; next cycle rd client1 addr 3
//    -> rd_valid=10, rd_data=DEADBEEF at T+1.
//  2 wr_req=11 held for 4 cycles -> wr_gnt sequence 01,10,01,10.
//    Same check on the read port with rd_req=11.
//  3 Client0 writes addr 5 = 32'h1234 while client1 reads addr 5 in the same cycle
//    -> rd_data=32'h1234 at T+1 (forwarded).
//  4 Registers 0..7 loaded; flush_req pulse -> busy=1 for 3 cycles, rf_clear=1 in cycle 3,
//    flush_done pulse in cycle 4; no grants during that time; all 8 reads then return 0.
//  5 rd granted at T, flush_req at T+1 -> response still delivered at T+1.
//    flush_req together with wr_req=01 -> wr_gnt=00 that cycle.
//  6 clear asserted during CLEAR state and with a read in flight
//    -> busy=0, rd_valid=00 next cycle; the next contention grants client 0.

Source files
------------

// File: rtl/rf_port_arbiter_pkg.sv
// Shared constants, flush FSM encoding and the 2-way round-robin pick function
// for the register-file port arbiter.
package rf_port_arbiter_pkg;

    localparam int RF_DATA_W    = 32;
    localparam int RF_ADDR_W    = 3;
    localparam int RF_N_CLIENTS = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2,
        ST_DONE  = 2'd3
    } flush_state_e;

    // On contention the client that was NOT granted last time wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
        logic [1:0] gnt;
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        return gnt;
    endfunction

endpackage

// File: rtl/rf_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with its own last-granted pointer.
// Grants are combinational; the pointer updates on every issued grant.
module rr_arb2
    import rf_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       clear,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        if (en && !clear) begin
            gnt = rr_pick(req, last_q);
            if (gnt[0]) begin
                last_d = 1'b0;
            end else if (gnt[1]) begin
                last_d = 1'b1;
            end
        end
    end

    // Reset to 1 so that client 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (clear) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/rf_port_arbiter.sv
// Shares the register file's single write and read port between two clients,
// returns registered read data with write-first forwarding, and sequences a full flush.
module rf_port_arbiter
    import rf_port_arbiter_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic                         clk,
    input  logic                         clear,
    input  logic [RF_N_CLIENTS-1:0]      wr_req,
    input  logic [RF_N_CLIENTS*ADDR_W-1:0] wr_addr,
    input  logic [RF_N_CLIENTS*DATA_W-1:0] wr_data,
    output logic [RF_N_CLIENTS-1:0]      wr_gnt,
    input  logic [RF_N_CLIENTS-1:0]      rd_req,
    input  logic [RF_N_CLIENTS*ADDR_W-1:0] rd_addr,
    output logic [RF_N_CLIENTS-1:0]      rd_gnt,
    output logic [RF_N_CLIENTS-1:0]      rd_valid,
    output logic [DATA_W-1:0]            rd_data,
    input  logic                         flush_req,
    output logic                         flush_done,
    output logic                         busy,
    output logic [1:0]                   dbg_state,
    output logic                         rf_clear,
    output logic                         rf_we,
    output logic [ADDR_W-1:0]            rf_wAddr,
    output logic [DATA_W-1:0]            rf_wData,
    output logic [ADDR_W-1:0]            rf_rAddr,
    input  logic [DATA_W-1:0]            rf_rData
);

    // Handshake: a transfer happens in a cycle where req[i] & gnt[i]; the client
    // holds req/addr/data stable until granted; read responses (rd_valid/rd_data)
    // arrive exactly one cycle after the grant and cannot be back-pressured.

    flush_state_e              state_q;
    flush_state_e              state_d;
    logic [RF_N_CLIENTS-1:0]   rd_valid_q;
    logic [RF_N_CLIENTS-1:0]   rd_valid_d;
    logic [DATA_W-1:0]         rd_data_q;
    logic [DATA_W-1:0]         rd_data_d;
    logic                      arb_en;
    logic                      fwd_hit;

    // A flush request in the same cycle as a client request blocks the grant.
    assign arb_en = (state_q == ST_IDLE) && !flush_req;

    rr_arb2 u_wr_arb (
        .clk   (clk),
        .clear (clear),
        .en    (arb_en),
        .req   (wr_req),
        .gnt   (wr_gnt)
    );

    rr_arb2 u_rd_arb (
        .clk   (clk),
        .clear (clear),
        .en    (arb_en),
        .req   (rd_req),
        .gnt   (rd_gnt)
    );

    always_comb begin
        rf_wAddr = '0;
        rf_wData = '0;
        if (wr_gnt[0]) begin
            rf_wAddr = wr_addr[0 +: ADDR_W];
            rf_wData = wr_data[0 +: DATA_W];
        end else if (wr_gnt[1]) begin
            rf_wAddr = wr_addr[ADDR_W +: ADDR_W];
            rf_wData = wr_data[DATA_W +: DATA_W];
        end
    end

    always_comb begin
        rf_rAddr = '0;
        if (rd_gnt[0]) begin
            rf_rAddr = rd_addr[0 +: ADDR_W];
        end else if (rd_gnt[1]) begin
            rf_rAddr = rd_addr[ADDR_W +: ADDR_W];
        end
    end

    assign rf_we = |wr_gnt;

    // Same-cycle write and read to one address returns the new data.
    assign fwd_hit = rf_we && (|rd_gnt) && (rf_wAddr == rf_rAddr);

    always_comb begin
        rd_valid_d = rd_gnt;
        rd_data_d  = rd_data_q;
        if (|rd_gnt) begin
            rd_data_d = fwd_hit ? rf_wData : rf_rData;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (flush_req) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_CLEAR;
            ST_CLEAR: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q    <= ST_IDLE;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign busy       = (state_q != ST_IDLE);
    assign flush_done = (state_q == ST_DONE);
    assign rf_clear   = clear || (state_q == ST_CLEAR);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Directed bench for rf_port_arbiter with a behavioural 8x32 register file attached.
module tb_rf_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 3;

  logic            clk;
  logic            clear;
  logic [1:0]      wr_req;
  logic [2*AW-1:0] wr_addr;
  logic [2*DW-1:0] wr_data;
  logic [1:0]      wr_gnt;
  logic [1:0]      rd_req;
  logic [2*AW-1:0] rd_addr;
  logic [1:0]      rd_gnt;
  logic [1:0]      rd_valid;
  logic [DW-1:0]   rd_data;
  logic            flush_req;
  logic            flush_done;
  logic            busy;
  logic [1:0]      dbg_state;
  logic            rf_clear;
  logic            rf_we;
  logic [AW-1:0]   rf_wAddr;
  logic [DW-1:0]   rf_wData;
  logic [AW-1:0]   rf_rAddr;
  logic [DW-1:0]   rf_rData;

  logic [DW-1:0]   mem [8];

  int checks;
  int errors;

  rf_port_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .clear      (clear),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_gnt     (wr_gnt),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_gnt     (rd_gnt),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .busy       (busy),
    .dbg_state  (dbg_state),
    .rf_clear   (rf_clear),
    .rf_we      (rf_we),
    .rf_wAddr   (rf_wAddr),
    .rf_wData   (rf_wData),
    .rf_rAddr   (rf_rAddr),
    .rf_rData   (rf_rData)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file stand-in
  always @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else if (rf_we) begin
      mem[rf_wAddr] <= rf_wData;
    end
  end
  assign rf_rData = mem[rf_rAddr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_req    = 2'b00;
    wr_addr   = '0;
    wr_data   = '0;
    rd_req    = 2'b00;
    rd_addr   = '0;
    flush_req = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    clear = 1'b1;
    step();
    step();
    clear = 1'b0;
  endtask

  task automatic set_wr(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_req[c]           = 1'b1;
    wr_addr[c*AW +: AW] = a;
    wr_data[c*DW +: DW] = d;
  endtask

  task automatic set_rd(input int c, input logic [AW-1:0] a);
    rd_req[c]           = 1'b1;
    rd_addr[c*AW +: AW] = a;
  endtask

  initial begin
    logic [1:0] seq [4];
    checks = 0;
    errors = 0;
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;

    // ---- 1: reset, then write 3 and read it back from client 1
    idle_inputs();
    clear = 1'b1;
    set_wr(0, 3'd1, 32'h1111_1111);
    #1;
    check("rst_wr_gnt", wr_gnt, 2'b00);
    check("rst_rf_clear", rf_clear, 1'b1);
    step();
    step();
    check("rst_busy", busy, 1'b0);
    check("rst_rd_valid", rd_valid, 2'b00);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_flush_done", flush_done, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    clear = 1'b0;
    idle_inputs();
    set_wr(0, 3'd3, 32'hDEAD_BEEF);
    #1;
    check("t1_wr_gnt", wr_gnt, 2'b01);
    check("t1_rf_we", rf_we, 1'b1);
    check("t1_rf_waddr", rf_wAddr, 3'd3);
    check("t1_rf_wdata", rf_wData, 32'hDEAD_BEEF);
    step();
    idle_inputs();
    set_rd(1, 3'd3);
    #1;
    check("t1_rd_gnt", rd_gnt, 2'b10);
    check("t1_rf_raddr", rf_rAddr, 3'd3);
    step();
    idle_inputs();
    check("t1_rd_valid", rd_valid, 2'b10);
    check("t1_rd_data", rd_data, 32'hDEAD_BEEF);

    // ---- 2: contention on each port alternates starting with client 0
    do_reset();
    set_wr(0, 3'd0, 32'hA0A0_A0A0);
    set_wr(1, 3'd1, 32'hA1A1_A1A1);
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("t2_wr_gnt%0d", k), wr_gnt, seq[k]);
      step();
    end
    idle_inputs();
    set_rd(0, 3'd0);
    set_rd(1, 3'd1);
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("t2_rd_gnt%0d", k), rd_gnt, seq[k]);
      step();
      check($sformatf("t2_rd_valid%0d", k), rd_valid, seq[k]);
      check($sformatf("t2_rd_data%0d", k), rd_data, (k % 2 == 0) ? 32'hA0A0_A0A0 : 32'hA1A1_A1A1);
    end
    idle_inputs();

    // ---- 3: forwarding on same address, plain read on a different one
    set_wr(0, 3'd5, 32'h0000_1234);
    set_rd(1, 3'd5);
    #1;
    check("t3_fwd_wr_gnt", wr_gnt, 2'b01);
    check("t3_fwd_rd_gnt", rd_gnt, 2'b10);
    step();
    check("t3_fwd_rd_data", rd_data, 32'h0000_1234);
    check("t3_fwd_rd_valid", rd_valid, 2'b10);
    idle_inputs();
    set_wr(0, 3'd6, 32'h0000_0077);
    set_rd(1, 3'd5);
    step();
    check("t3_nofwd_rd_data", rd_data, 32'h0000_1234);
    idle_inputs();
    set_rd(0, 3'd6);
    step();
    check("t3_readback6", rd_data, 32'h0000_0077);
    idle_inputs();

    // ---- 4: load all registers, flush, then every register reads 0
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      set_wr(1, i[AW-1:0], 32'h100 + i);
      step();
    end
    idle_inputs();
    set_rd(0, 3'd7);
    step();
    check("t4_pre_rd7", rd_data, 32'h107);
    idle_inputs();
    flush_req = 1'b1;
    #1;
    check("t4_req_busy", busy, 1'b0);
    check("t4_req_rd_gnt", rd_gnt, 2'b00);
    step();
    flush_req = 1'b0;
    set_rd(0, 3'd0);
    #1;
    check("t4_drain_busy", busy, 1'b1);
    check("t4_drain_state", dbg_state, 2'd1);
    check("t4_drain_rf_clear", rf_clear, 1'b0);
    check("t4_drain_rd_gnt", rd_gnt, 2'b00);
    step();
    check("t4_clear_busy", busy, 1'b1);
    check("t4_clear_rf_clear", rf_clear, 1'b1);
    check("t4_clear_rd_gnt", rd_gnt, 2'b00);
    check("t4_clear_done", flush_done, 1'b0);
    step();
    check("t4_done_busy", busy, 1'b1);
    check("t4_done_flush_done", flush_done, 1'b1);
    check("t4_done_rf_clear", rf_clear, 1'b0);
    check("t4_done_rd_gnt", rd_gnt, 2'b00);
    step();
    check("t4_idle_busy", busy, 1'b0);
    check("t4_idle_flush_done", flush_done, 1'b0);
    check("t4_idle_rd_gnt", rd_gnt, 2'b01);
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      set_rd(0, i[AW-1:0]);
      step();
      check($sformatf("t4_post_rd%0d_valid", i), rd_valid, 2'b01);
      check($sformatf("t4_post_rd%0d_data", i), rd_data, 32'h0);
    end
    idle_inputs();

    // ---- 5: read granted before flush still returns; flush beats a write
    set_wr(0, 3'd2, 32'h0000_0055);
    step();
    idle_inputs();
    set_rd(0, 3'd2);
    #1;
    check("t5_rd_gnt", rd_gnt, 2'b01);
    step();
    idle_inputs();
    flush_req = 1'b1;
    set_wr(0, 3'd1, 32'h0000_0BAD);
    #1;
    check("t5_flush_wr_gnt", wr_gnt, 2'b00);
    check("t5_flush_rf_we", rf_we, 1'b0);
    check("t5_resp_valid", rd_valid, 2'b01);
    check("t5_resp_data", rd_data, 32'h0000_0055);
    step();
    idle_inputs();
    check("t5_drain_busy", busy, 1'b1);
    step();
    step();
    step();
    check("t5_back_idle", busy, 1'b0);

    // ---- 6: reset drops an in-flight read, aborts a flush, restores pointers
    do_reset();
    set_wr(0, 3'd4, 32'h0000_0099);
    step();
    idle_inputs();
    set_rd(0, 3'd4);
    #1;
    check("t6_rd_gnt", rd_gnt, 2'b01);
    step();
    check("t6_rd_valid_pre", rd_valid, 2'b01);
    check("t6_rd_data_pre", rd_data, 32'h0000_0099);
    clear = 1'b1;
    idle_inputs();
    step();
    check("t6_rd_valid_drop", rd_valid, 2'b00);
    check("t6_busy_rst", busy, 1'b0);
    clear = 1'b0;
    set_wr(0, 3'd0, 32'h1);
    set_wr(1, 3'd1, 32'h2);
    set_rd(0, 3'd0);
    set_rd(1, 3'd1);
    #1;
    check("t6_wr_contend", wr_gnt, 2'b01);
    check("t6_rd_contend", rd_gnt, 2'b01);
    step();
    idle_inputs();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    step();
    check("t6_in_clear", dbg_state, 2'd2);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t6_abort_busy", busy, 1'b0);
    check("t6_abort_state", dbg_state, 2'd0);
    check("t6_abort_done", flush_done, 1'b0);
    step();
    check("t6_stay_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
